// File: rtl/epoch_counter.sv
// epoch_counter: 1 ms code-epoch cycle/bit counter with TIC snapshot and deferred software load.
// Optional frame_pulse output is compiled in when EPOCH_FRAME_PULSE_EN is defined.
module epoch_counter #(
    parameter int unsigned CYC_MAX = 20,
    parameter int unsigned BIT_MAX = 50,
    parameter int unsigned CYC_W   = 5,
    parameter int unsigned BIT_W   = 6
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     tic_enable,
    input  logic                     dump_enable,
    input  logic                     epoch_load_en,
    input  logic [CYC_W+BIT_W-1:0]   epoch_load,
    output logic [CYC_W+BIT_W-1:0]   epoch,
    output logic [CYC_W+BIT_W-1:0]   epoch_check,
    output logic                     load_pending
`ifdef EPOCH_FRAME_PULSE_EN
    ,
    output logic                     frame_pulse
`endif
);

    localparam int unsigned      EW       = CYC_W + BIT_W;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYC_MAX - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_MAX - 1);

    typedef enum logic {
        LOAD_IDLE,
        LOAD_PENDING
    } load_state_t;

    load_state_t      state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [CYC_W-1:0] pend_cyc_q, pend_cyc_d;
    logic [BIT_W-1:0] pend_bit_q, pend_bit_d;
    logic [EW-1:0]    epoch_q, epoch_d;
    logic [CYC_W-1:0] ld_cyc;
    logic [BIT_W-1:0] ld_bit;
`ifdef EPOCH_FRAME_PULSE_EN
    logic             frame_q, frame_d;
`endif

    // Out-of-range fields are zeroed independently when the load is captured.
    always_comb begin
        ld_cyc = epoch_load[CYC_W-1:0];
        ld_bit = epoch_load[EW-1:CYC_W];
        if (ld_cyc > CYC_LAST) ld_cyc = '0;
        if (ld_bit > BIT_LAST) ld_bit = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= LOAD_IDLE;
            cyc_q      <= '0;
            bit_q      <= '0;
            pend_cyc_q <= '0;
            pend_bit_q <= '0;
            epoch_q    <= '0;
`ifdef EPOCH_FRAME_PULSE_EN
            frame_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            pend_cyc_q <= pend_cyc_d;
            pend_bit_q <= pend_bit_d;
            epoch_q    <= epoch_d;
`ifdef EPOCH_FRAME_PULSE_EN
            frame_q    <= frame_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        pend_cyc_d = pend_cyc_q;
        pend_bit_d = pend_bit_q;
`ifdef EPOCH_FRAME_PULSE_EN
        frame_d    = 1'b0;
`endif

        // TIC snapshots the pre-update count regardless of dump/load activity.
        epoch_d = tic_enable ? {bit_q, cyc_q} : epoch_q;

        if (dump_enable) begin
            state_d = LOAD_IDLE;
            if (epoch_load_en) begin
                cyc_d = ld_cyc;
                bit_d = ld_bit;
            end else if (state_q == LOAD_PENDING) begin
                cyc_d = pend_cyc_q;
                bit_d = pend_bit_q;
            end else if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
                if (bit_q == BIT_LAST) begin
                    bit_d = '0;
`ifdef EPOCH_FRAME_PULSE_EN
                    frame_d = 1'b1;
`endif
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end else if (epoch_load_en) begin
            state_d    = LOAD_PENDING;
            pend_cyc_d = ld_cyc;
            pend_bit_d = ld_bit;
        end
    end

    assign epoch        = epoch_q;
    assign epoch_check  = {bit_q, cyc_q};
    assign load_pending = (state_q == LOAD_PENDING);
`ifdef EPOCH_FRAME_PULSE_EN
    assign frame_pulse  = frame_q;
`endif

endmodule
